bus_source_decoder: RTL

- Drives the datapath bus-source enables from a 5-bit source code, the inverse of the bus-source encoder. Code 1..24 maps to R0..R15, HI, LO, ZHI, ZLO, PC, MDR, Inport, C.
- Sits between the control unit and the bus mux. It registers the code, asserts exactly one drive enable for a programmable number of cycles, then releases the bus.
- Flags illegal codes with a sticky error.

---
 rtl/bus_source_decoder.sv | 101 ++++++++++
 1 files changed

// File: rtl/bus_source_decoder.sv
// Bus-source decoder: registers a 5-bit source code and drives exactly one
// bus-source enable for hold_cycles+1 cycles, with sticky illegal-code flag.
module bus_source_decoder #(
  parameter int unsigned HOLD_W = 4
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              code_valid,
  input  logic [4:0]        code,
  input  logic [HOLD_W-1:0] hold_cycles,
  input  logic              abort,
  input  logic              clear_err,
  output logic              ready,
  output logic [23:0]       src_en,
  output logic              drive_active,
  output logic              bad_code
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t            state;
  logic [HOLD_W-1:0] cnt;
  logic              accept;
  logic              code_legal;
  logic              code_illegal;
  logic [23:0]       onehot;

  // Final drive cycle doubles as an accept window for a gapless handoff.
  always_comb begin
    ready = ~clear & ~abort & ((state == IDLE) | (cnt == '0));
  end

  always_comb begin
    accept       = code_valid & ready;
    code_legal   = (code != 5'd0) && (code <= 5'd24);
    code_illegal = (code > 5'd24);
    onehot       = '0;
    for (int unsigned i = 0; i < 24; i++) begin
      if (code == 5'(i + 1)) onehot[i] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state        <= IDLE;
      cnt          <= '0;
      src_en       <= '0;
      drive_active <= 1'b0;
      bad_code     <= 1'b0;
    end else begin
      // Set beats clear_err; abort leaves the flag alone.
      if (accept && code_illegal) begin
        bad_code <= 1'b1;
      end else if (clear_err) begin
        bad_code <= 1'b0;
      end

      if (abort) begin
        state        <= IDLE;
        cnt          <= '0;
        src_en       <= '0;
        drive_active <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (accept && code_legal) begin
              state        <= DRIVE;
              cnt          <= hold_cycles;
              src_en       <= onehot;
              drive_active <= 1'b1;
            end
          end
          DRIVE: begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else if (accept && code_legal) begin
              state        <= DRIVE;
              cnt          <= hold_cycles;
              src_en       <= onehot;
              drive_active <= 1'b1;
            end else begin
              state        <= IDLE;
              src_en       <= '0;
              drive_active <= 1'b0;
            end
          end
          default: begin
            state        <= IDLE;
            cnt          <= '0;
            src_en       <= '0;
            drive_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
